barrel_shift_engine: RTL and testbench

BARREL_SHIFT_ENGINE -- requirements
Module: barrel_shift_engine

---
 rtl/barrel_shift_engine.sv | 181 ++++++++++++++++++
 tb/tb_barrel_shift_engine.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/barrel_shift_engine.sv
// rtl/barrel_shift_engine.sv - pipelined barrel shifter/rotator with valid/ready flow control
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   in_valid/in_ready       operation handshake
//   in_data, in_shamt       operand and shift amount
//   in_mode                 000 ROL, 001 ROR, 010 SLL, 011 SRL, 100 SRA, others illegal
//   in_tag                  sideband tag carried with the operation
//   out_valid/out_ready     result handshake
//   out_data, out_tag       result and its tag
//   out_zero, out_illegal   result is zero / operation used an illegal mode
//   busy                    any pipeline stage holds an operation
module barrel_shift_engine #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_STAGES = 2,
   parameter int TAG_WIDTH  = 4,
   localparam int SA_WIDTH  = $clog2(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [SA_WIDTH-1:0]   in_shamt,
   input  logic [2:0]            in_mode,
   input  logic [TAG_WIDTH-1:0]  in_tag,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [TAG_WIDTH-1:0]  out_tag,
   output logic                  out_zero,
   output logic                  out_illegal,
   output logic                  busy
);

   localparam int NS    = NUM_STAGES;
   localparam int LAST  = NS - 1;
   // Stages before the last one carry the not-yet-applied shamt bits and the mode.
   localparam int MS    = (NS > 1) ? NS - 1 : 1;
   localparam int BASE  = SA_WIDTH / NS;
   localparam int EXTRA = SA_WIDTH % NS;

   localparam logic [2:0] MODE_ROL = 3'b000;
   localparam logic [2:0] MODE_ROR = 3'b001;
   localparam logic [2:0] MODE_SLL = 3'b010;
   localparam logic [2:0] MODE_SRL = 3'b011;
   localparam logic [2:0] MODE_SRA = 3'b100;

   logic                  vld_q   [NS];
   logic [DATA_WIDTH-1:0] data_q  [NS];
   logic [TAG_WIDTH-1:0]  tag_q   [NS];
   logic [SA_WIDTH-1:0]   shamt_q [MS];
   logic [2:0]            mode_q  [MS];
   logic                  zero_q;
   logic                  ill_q;
   logic [NS-1:0]         en;
   logic                  busy_c;

   // Partial shifts compose: applying disjoint shamt bit groups one after
   // another equals the full shift for every mode. SRA keeps the sign bit
   // in place, so later stages still fill with the original sign.
   function automatic logic [DATA_WIDTH-1:0] shift_op(
      input logic [DATA_WIDTH-1:0] d,
      input logic [SA_WIDTH-1:0]   a,
      input logic [2:0]            m
   );
      logic [2*DATA_WIDTH-1:0] dd;
      logic [2*DATA_WIDTH-1:0] tmp;
      dd  = {d, d};
      tmp = '0;
      case (m)
         MODE_ROL: begin
            tmp = dd << a;
            return tmp[2*DATA_WIDTH-1:DATA_WIDTH];
         end
         MODE_ROR: begin
            tmp = dd >> a;
            return tmp[DATA_WIDTH-1:0];
         end
         MODE_SLL: return d << a;
         MODE_SRL: return d >> a;
         MODE_SRA: return DATA_WIDTH'($signed(d) >>> a);
         default:  return d;
      endcase
   endfunction

   // Load enables, resolved from the output back towards the input: a stage
   // may load when it is empty or its content moves on in this cycle.
   always_comb begin
      en       = '0;
      en[LAST] = !vld_q[LAST] || out_ready;
      for (int p = LAST - 1; p >= 0; p--) begin
         en[p] = !vld_q[p] || en[p+1];
      end
   end

   always_comb begin
      busy_c = 1'b0;
      for (int p = 0; p < NS; p++) begin
         busy_c = busy_c | vld_q[p];
      end
   end

   generate
      for (genvar p = 0; p < NS; p++) begin : g_stage
         // Lower-indexed stages take the extra shamt bit when the split is uneven.
         localparam int LO  = p * BASE + ((p < EXTRA) ? p : EXTRA);
         localparam int CNT = BASE + ((p < EXTRA) ? 1 : 0);
         localparam logic [SA_WIDTH-1:0] MASK = SA_WIDTH'(((1 << CNT) - 1) << LO);

         logic                  src_vld;
         logic [DATA_WIDTH-1:0] src_data;
         logic [TAG_WIDTH-1:0]  src_tag;
         logic [SA_WIDTH-1:0]   src_shamt;
         logic [2:0]            src_mode;
         logic [DATA_WIDTH-1:0] nxt_data;

         if (p == 0) begin : g_src_in
            assign src_vld   = in_valid;
            assign src_data  = in_data;
            assign src_tag   = in_tag;
            assign src_shamt = in_shamt;
            assign src_mode  = in_mode;
         end else begin : g_src_prev
            assign src_vld   = vld_q[p-1];
            assign src_data  = data_q[p-1];
            assign src_tag   = tag_q[p-1];
            assign src_shamt = shamt_q[p-1];
            assign src_mode  = mode_q[p-1];
         end

         assign nxt_data = shift_op(src_data, src_shamt & MASK, src_mode);

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               vld_q[p]  <= 1'b0;
               data_q[p] <= '0;
               tag_q[p]  <= '0;
            end else if (en[p]) begin
               vld_q[p]  <= src_vld;
               data_q[p] <= nxt_data;
               tag_q[p]  <= src_tag;
            end
         end

         if (p < LAST) begin : g_mid
            always_ff @(posedge clk or negedge reset_n) begin
               if (!reset_n) begin
                  shamt_q[p] <= '0;
                  mode_q[p]  <= '0;
               end else if (en[p]) begin
                  shamt_q[p] <= src_shamt & ~MASK;
                  mode_q[p]  <= src_mode;
               end
            end
         end else begin : g_last
            // Result flags are captured with the final data so they are
            // stable while the output is stalled.
            always_ff @(posedge clk or negedge reset_n) begin
               if (!reset_n) begin
                  zero_q <= 1'b0;
                  ill_q  <= 1'b0;
               end else if (en[p]) begin
                  zero_q <= (nxt_data == '0);
                  ill_q  <= (src_mode > MODE_SRA);
               end
            end
         end
      end
   endgenerate

   // Gated by reset_n so nothing is offered acceptance while reset is held.
   assign in_ready    = en[0] && reset_n;
   assign out_valid   = vld_q[LAST];
   assign out_data    = data_q[LAST];
   assign out_tag     = tag_q[LAST];
   assign out_zero    = zero_q;
   assign out_illegal = ill_q;
   assign busy        = busy_c;

endmodule

// File: tb/tb_barrel_shift_engine.sv
// tb/tb_barrel_shift_engine.sv - self-checking bench for barrel_shift_engine
module tb_barrel_shift_engine;

   logic        clk;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [4:0]  in_shamt;
   logic [2:0]  in_mode;
   logic [3:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [3:0]  out_tag;
   logic        out_zero;
   logic        out_illegal;
   logic        busy;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  tag;
      logic        zero;
      logic        ill;
   } exp_t;

   exp_t sb[$];
   int   pass_cnt = 0;
   int   chk_cnt  = 0;
   logic acc;

   barrel_shift_engine #(.DATA_WIDTH(32), .NUM_STAGES(2), .TAG_WIDTH(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_shamt(in_shamt), .in_mode(in_mode), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_tag(out_tag), .out_zero(out_zero), .out_illegal(out_illegal),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   // Bit-by-bit reference: result bit i is picked from its source position.
   function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s, input logic [2:0] m);
      logic [31:0] r;
      r = d;
      for (int i = 0; i < 32; i++) begin
         case (m)
            3'd0: r[i] = d[(i - s + 32) % 32];
            3'd1: r[i] = d[(i + s) % 32];
            3'd2: if (i >= s) r[i] = d[i - s]; else r[i] = 1'b0;
            3'd3: if (i + s < 32) r[i] = d[i + s]; else r[i] = 1'b0;
            3'd4: if (i + s < 32) r[i] = d[i + s]; else r[i] = d[31];
            default: r[i] = d[i];
         endcase
      end
      return r;
   endfunction

   // One clock cycle: drive at the falling edge, settle, then record the
   // accept into the scoreboard and compare any result leaving the DUT.
   task automatic step(input logic iv, input logic [31:0] d, input logic [4:0] s,
                       input logic [2:0] m, input logic [3:0] t, input logic [31:0] exp_d,
                       input logic ordy, output logic accepted);
      exp_t push_e;
      exp_t want;
      exp_t got;
      @(negedge clk);
      in_valid  = iv;
      in_data   = d;
      in_shamt  = s;
      in_mode   = m;
      in_tag    = t;
      out_ready = ordy;
      #4;
      accepted = in_valid && in_ready;
      if (accepted) begin
         push_e.data = exp_d;
         push_e.tag  = t;
         push_e.zero = (exp_d == 32'h0);
         push_e.ill  = (m > 3'd4);
         sb.push_back(push_e);
      end
      if (out_valid && out_ready) begin
         chk_cnt++;
         got = {out_data, out_tag, out_zero, out_illegal};
         if (sb.size() == 0) begin
            $display("FAIL unexpected_output got data=%h tag=%h", out_data, out_tag);
         end else begin
            want = sb.pop_front();
            if (got !== want)
               $display("FAIL result got data=%h tag=%h zero=%b ill=%b expected data=%h tag=%h zero=%b ill=%b",
                        got.data, got.tag, got.zero, got.ill, want.data, want.tag, want.zero, want.ill);
            else
               pass_cnt++;
         end
      end
   endtask

   task automatic drain(input string name);
      logic a;
      for (int k = 0; k < 10 && (sb.size() != 0 || busy); k++)
         step(1'b0, 32'h0, 5'd0, 3'd0, 4'd0, 32'h0, 1'b1, a);
      chk_cnt++;
      if (sb.size() != 0 || busy)
         $display("FAIL %s_drain got pending=%0d busy=%b expected pending=0 busy=0", name, sb.size(), busy);
      else
         pass_cnt++;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk_cnt++;
      if ({out_valid, busy, in_ready, out_zero, out_illegal, out_data, out_tag} !== 41'h0)
         $display("FAIL reset_state got valid=%b busy=%b ready=%b zero=%b ill=%b data=%h tag=%h expected all zero",
                  out_valid, busy, in_ready, out_zero, out_illegal, out_data, out_tag);
      else
         pass_cnt++;
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk_cnt++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0)
         $display("FAIL reset_release got ready=%b valid=%b expected ready=1 valid=0", in_ready, out_valid);
      else
         pass_cnt++;
   endtask

   task automatic test_vectors;
      logic [31:0] vd [13] = '{32'h80000001, 32'h80000000, 32'h80000000, 32'h00000001, 32'h00000002,
                               32'h1234ABCD, 32'hDEADBEEF, 32'h80000000, 32'h00000000, 32'h7FFFFFF0,
                               32'h12345678, 32'h0000000F, 32'hF0000000};
      logic [4:0]  vs [13] = '{5'd1, 5'd31, 5'd31, 5'd4, 5'd31, 5'd3, 5'd0, 5'd0, 5'd0, 5'd4, 5'd8, 5'd9, 5'd12};
      logic [2:0]  vm [13] = '{3'd0, 3'd4, 3'd3, 3'd1, 3'd2, 3'd7, 3'd0, 3'd4, 3'd5, 3'd4, 3'd1, 3'd2, 3'd0};
      logic [31:0] ve [13] = '{32'h00000003, 32'hFFFFFFFF, 32'h00000001, 32'h10000000, 32'h00000000,
                               32'h1234ABCD, 32'hDEADBEEF, 32'h80000000, 32'h00000000, 32'h07FFFFFF,
                               32'h78123456, 32'h00001E00, 32'h00000F00};
      logic a;
      // First vector alone to pin the two-cycle latency.
      step(1'b1, vd[0], vs[0], vm[0], 4'h5, ve[0], 1'b1, a);
      chk_cnt++;
      if (a !== 1'b1) $display("FAIL rol_accept got %b expected 1", a); else pass_cnt++;
      step(1'b0, 32'h0, 5'd0, 3'd0, 4'd0, 32'h0, 1'b1, a);
      chk_cnt++;
      if (out_valid !== 1'b0) $display("FAIL latency_early got out_valid=%b expected 0", out_valid); else pass_cnt++;
      step(1'b0, 32'h0, 5'd0, 3'd0, 4'd0, 32'h0, 1'b1, a);
      chk_cnt++;
      if (out_valid !== 1'b1) $display("FAIL latency_two got out_valid=%b expected 1", out_valid); else pass_cnt++;
      for (int i = 1; i < 13; i++) begin
         step(1'b1, vd[i], vs[i], vm[i], 4'(i), ve[i], 1'b1, a);
         chk_cnt++;
         if (a !== 1'b1) $display("FAIL vec_accept_%0d got %b expected 1", i, a); else pass_cnt++;
      end
      drain("vectors");
   endtask

   task automatic test_back_to_back_stall;
      int   next = 0;
      logic a;
      logic ordy;
      logic [37:0] held;
      for (int k = 1; k <= 25 && (next < 5 || sb.size() != 0); k++) begin
         ordy = !(k >= 2 && k <= 6);
         if (next < 5)
            step(1'b1, 32'h01234567 << next, 5'(next + 1), 3'd0, 4'(next),
                 ref_shift(32'h01234567 << next, next + 1, 3'd0), ordy, a);
         else
            step(1'b0, 32'h0, 5'd0, 3'd0, 4'd0, 32'h0, ordy, a);
         if (a) next++;
         if (k == 2) begin
            chk_cnt++;
            if (a !== 1'b1) $display("FAIL stall_second_accept got %b expected 1", a); else pass_cnt++;
         end
         if (k >= 3 && k <= 6) begin
            chk_cnt++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1)
               $display("FAIL stall_full_%0d got ready=%b valid=%b expected ready=0 valid=1", k, in_ready, out_valid);
            else
               pass_cnt++;
            if (k == 3) begin
               held = {out_data, out_tag, out_zero, out_illegal};
            end else begin
               chk_cnt++;
               if ({out_data, out_tag, out_zero, out_illegal} !== held)
                  $display("FAIL stall_hold_%0d got %h expected %h", k, {out_data, out_tag, out_zero, out_illegal}, held);
               else
                  pass_cnt++;
            end
         end
      end
      chk_cnt++;
      if (next != 5) $display("FAIL stall_accept_count got %0d expected 5", next); else pass_cnt++;
      drain("stall");
   endtask

   task automatic test_reset_in_flight;
      logic a0;
      logic a1;
      int   seen = 0;
      step(1'b1, 32'hAAAA0001, 5'd3, 3'd1, 4'hA, ref_shift(32'hAAAA0001, 3, 3'd1), 1'b0, a0);
      step(1'b1, 32'h5555FFFF, 5'd7, 3'd2, 4'hB, ref_shift(32'h5555FFFF, 7, 3'd2), 1'b0, a1);
      chk_cnt++;
      if ({a0, a1} !== 2'b11) $display("FAIL flight_accepts got %b expected 11", {a0, a1}); else pass_cnt++;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk_cnt++;
      if (busy !== 1'b1 || out_valid !== 1'b1)
         $display("FAIL flight_loaded got busy=%b valid=%b expected 1 1", busy, out_valid);
      else
         pass_cnt++;
      reset_n = 1'b0;
      #1;
      chk_cnt++;
      if ({out_valid, busy, out_zero, out_illegal, out_data, out_tag} !== 40'h0)
         $display("FAIL async_reset got valid=%b busy=%b zero=%b ill=%b data=%h tag=%h expected all zero",
                  out_valid, busy, out_zero, out_illegal, out_data, out_tag);
      else
         pass_cnt++;
      sb.delete();
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk_cnt++;
      if (in_ready !== 1'b1) $display("FAIL flight_release_ready got %b expected 1", in_ready); else pass_cnt++;
      for (int k = 0; k < 6; k++) begin
         step(1'b0, 32'h0, 5'd0, 3'd0, 4'd0, 32'h0, 1'b1, a0);
         if (out_valid) seen++;
      end
      chk_cnt++;
      if (seen != 0) $display("FAIL flight_discard got %0d outputs expected 0", seen); else pass_cnt++;
   endtask

   task automatic test_random_stream;
      logic [31:0] d;
      logic [4:0]  s;
      logic [2:0]  m;
      logic        a;
      int          acc_n = 0;
      int          bubbles = 0;
      for (int i = 0; i < 100; i++) begin
         d = $urandom;
         if (i % 10 == 3) d = 32'h0;
         s = 5'($urandom_range(0, 31));
         m = 3'($urandom_range(0, 7));
         step(1'b1, d, s, m, 4'(i), ref_shift(d, int'(s), m), 1'b1, a);
         if (a) acc_n++;
         if (i >= 2 && !out_valid) bubbles++;
      end
      chk_cnt++;
      if (acc_n != 100 || bubbles != 0)
         $display("FAIL random_throughput got accepted=%0d bubbles=%0d expected 100 and 0", acc_n, bubbles);
      else
         pass_cnt++;
      drain("random");
   endtask

   initial begin
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_shamt  = '0;
      in_mode   = '0;
      in_tag    = '0;
      out_ready = 1'b0;
      acc       = 1'b0;
      test_reset;
      test_vectors;
      test_back_to_back_stall;
      test_reset_in_flight;
      test_random_stream;
      chk_cnt++;
      if (sb.size() != 0) $display("FAIL final_scoreboard got %0d pending expected 0", sb.size()); else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
